// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the JTAG TAP controller: TAP state encoding,
// instruction register width, opcodes and the DR-select decode.
package jtag_tap_pkg;

  localparam int IR_WIDTH = 4;
  localparam int ID_WIDTH = 32;

  typedef logic [IR_WIDTH-1:0] ir_t;

  // Public instruction opcodes; every unlisted code behaves as BYPASS.
  localparam ir_t OP_EXTEST         = 4'b0000;
  localparam ir_t OP_SAMPLE_PRELOAD = 4'b0001;
  localparam ir_t OP_IDCODE         = 4'b0010;
  localparam ir_t OP_BYPASS         = 4'b1111;

  // Fixed pattern captured into the IR shift stage; its two LSBs are the
  // mandatory 01 that lets a tester find IR boundaries in a chain.
  localparam ir_t IR_CAPTURE = 4'b0101;

  // Classic 1149.1 encoding: bit 3 separates the IR column from the DR
  // column for most states, which keeps the decode easy to read in waves.
  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PAU_DR = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PAU_IR = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  // Which data register sits between TDI and TDO for the current IR.
  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_BSCAN
  } dr_sel_e;

  function automatic dr_sel_e decode_dr(input ir_t ir);
    dr_sel_e sel;
    case (ir)
      OP_EXTEST,
      OP_SAMPLE_PRELOAD: sel = DR_BSCAN;
      OP_IDCODE:         sel = DR_IDCODE;
      default:           sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage : jtag_tap_pkg

// File: rtl/jtag_tap_ctrl_if.sv
// Boundary-scan chain bundle: the control strobes the TAP drives into the
// chain and the chain's serial return. The TAP is the master side, the
// chain of boundary cells is the slave side.
interface jtag_tap_ctrl_if;

  logic shift_dr;
  logic capture_dr;
  logic update_dr;
  logic bs_enable;
  logic bs_mode;
  logic bs_si;
  logic bs_so;

  modport master (
    output shift_dr,
    output capture_dr,
    output update_dr,
    output bs_enable,
    output bs_mode,
    output bs_si,
    input  bs_so
  );

  modport slave (
    input  shift_dr,
    input  capture_dr,
    input  update_dr,
    input  bs_enable,
    input  bs_mode,
    input  bs_si,
    output bs_so
  );

endinterface : jtag_tap_ctrl_if

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine. Advances on every TCK rise
// according to TMS; five consecutive TMS=1 rises reach Test-Logic-Reset
// from any state, and TRST_N forces it asynchronously.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q;
  tap_state_e state_d;

  // State register, reset to Test-Logic-Reset.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection from the current state and TMS.
  // NOTE: state_d gets a default before the case so that no path through
  // this block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_TLR:    state_d = tms_i ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_d = tms_i ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: state_d = tms_i ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: state_d = tms_i ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_d = tms_i ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: state_d = tms_i ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: state_d = tms_i ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      default:    state_d = TAP_TLR;
    endcase
  end

  assign state_o = state_q;

endmodule : jtag_tap_fsm

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: TAP FSM, 4-bit instruction register, IDCODE and
// BYPASS data registers, and boundary-scan chain control. Registers
// update on TCK rise; TDO and its enable are retimed to TCK fall so the
// tester sees stable data at the next rise.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter logic [ID_WIDTH-1:0] IDCODE_VALUE = 32'h1234_5677
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic shift_dr_o,
  output logic capture_dr_o,
  output logic update_dr_o,
  output logic bs_enable_o,
  output logic bs_mode_o,
  output logic bs_si_o,
  input  logic bs_so_i
);

  // An IDCODE with bit 0 clear would be mistaken for a BYPASS register.
  if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE_VALUE bit 0 must be 1");
  end

  tap_state_e state;

  ir_t                 ir_q,    ir_d;
  ir_t                 ir_sr_q, ir_sr_d;
  logic [ID_WIDTH-1:0] id_sr_q, id_sr_d;
  logic                byp_q,   byp_d;
  logic                tdo_q,   tdo_d;
  logic                tdo_oe_q, tdo_oe_d;

  ir_t     ir_cur;
  dr_sel_e dr_sel;

  jtag_tap_fsm u_fsm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .tms_i   (tms_i),
    .state_o (state)
  );

  // IDCODE is forced the moment the FSM lands in Test-Logic-Reset, without
  // waiting for the IR flop to reload on the following rise.
  assign ir_cur = (state == TAP_TLR) ? OP_IDCODE : ir_q;
  assign dr_sel = decode_dr(ir_cur);

  // Chain strobes follow the current state only; the IR does not gate them.
  assign shift_dr_o   = (state == TAP_SH_DR);
  assign capture_dr_o = (state == TAP_CAP_DR);
  assign update_dr_o  = (state == TAP_UPD_DR);
  assign bs_enable_o  = (dr_sel == DR_BSCAN);
  assign bs_mode_o    = (ir_cur == OP_EXTEST);
  assign bs_si_o      = tdi_i;

  // Capture/shift/update of IR and data registers; Pause and Exit states
  // fall through to the defaults and hold every register.
  always_comb begin
    ir_d    = ir_q;
    ir_sr_d = ir_sr_q;
    id_sr_d = id_sr_q;
    byp_d   = byp_q;
    case (state)
      TAP_TLR:    ir_d    = OP_IDCODE;
      TAP_CAP_IR: ir_sr_d = IR_CAPTURE;
      TAP_SH_IR:  ir_sr_d = {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
      TAP_UPD_IR: ir_d    = ir_sr_q;
      TAP_CAP_DR: begin
        byp_d = 1'b0;
        if (dr_sel == DR_IDCODE) begin
          id_sr_d = IDCODE_VALUE;
        end
      end
      TAP_SH_DR: begin
        byp_d   = tdi_i;
        id_sr_d = {tdi_i, id_sr_q[ID_WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  // TCK-rise register bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir_q    <= OP_IDCODE;
      ir_sr_q <= '0;
      id_sr_q <= '0;
      byp_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      id_sr_q <= id_sr_d;
      byp_q   <= byp_d;
    end
  end

  // TDO source mux; output parks low whenever the TAP is not shifting.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    case (state)
      TAP_SH_IR: begin
        tdo_d    = ir_sr_q[0];
        tdo_oe_d = 1'b1;
      end
      TAP_SH_DR: begin
        tdo_oe_d = 1'b1;
        case (dr_sel)
          DR_IDCODE: tdo_d = id_sr_q[0];
          DR_BSCAN:  tdo_d = bs_so_i;
          default:   tdo_d = byp_q;
        endcase
      end
      default: ;
    endcase
  end

  // TDO retimed on TCK fall, half a cycle ahead of the tester's sample.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo_o    = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule : jtag_tap_ctrl

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: a queue-based reference model of
// the TAP registers checked every cycle, directed scan sequences, a state
// table walk through all 16 TAP states, and a randomized TMS/TDI phase.
module tb_jtag_tap_ctrl;
  import jtag_tap_pkg::*;

  localparam logic [31:0] IDC = 32'h1234_5677;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic tms_i  = 1'b1;
  logic tdi_i  = 1'b0;
  logic tdo_o;
  logic tdo_oe_o;

  jtag_tap_ctrl_if bs_if ();

  jtag_tap_ctrl #(.IDCODE_VALUE(IDC)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tms_i        (tms_i),
    .tdi_i        (tdi_i),
    .tdo_o        (tdo_o),
    .tdo_oe_o     (tdo_oe_o),
    .shift_dr_o   (bs_if.shift_dr),
    .capture_dr_o (bs_if.capture_dr),
    .update_dr_o  (bs_if.update_dr),
    .bs_enable_o  (bs_if.bs_enable),
    .bs_mode_o    (bs_if.bs_mode),
    .bs_si_o      (bs_if.bs_si),
    .bs_so_i      (bs_if.bs_so)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Successor table from the TAP state diagram: succ[state][tms].
  tap_state_e succ [16][2];
  tap_state_e m_state;
  ir_t        m_ir;
  bit         m_irq [$];   // IR shift stage, front = bit nearest TDO
  bit         m_drq [$];   // selected data register, front = bit nearest TDO
  bit         m_chain;     // boundary chain selected: TDO comes from bs_so

  function automatic void init_table();
    succ[TAP_TLR]    = '{TAP_RTI,    TAP_TLR};
    succ[TAP_RTI]    = '{TAP_RTI,    TAP_SEL_DR};
    succ[TAP_SEL_DR] = '{TAP_CAP_DR, TAP_SEL_IR};
    succ[TAP_CAP_DR] = '{TAP_SH_DR,  TAP_EX1_DR};
    succ[TAP_SH_DR]  = '{TAP_SH_DR,  TAP_EX1_DR};
    succ[TAP_EX1_DR] = '{TAP_PAU_DR, TAP_UPD_DR};
    succ[TAP_PAU_DR] = '{TAP_PAU_DR, TAP_EX2_DR};
    succ[TAP_EX2_DR] = '{TAP_SH_DR,  TAP_UPD_DR};
    succ[TAP_UPD_DR] = '{TAP_RTI,    TAP_SEL_DR};
    succ[TAP_SEL_IR] = '{TAP_CAP_IR, TAP_TLR};
    succ[TAP_CAP_IR] = '{TAP_SH_IR,  TAP_EX1_IR};
    succ[TAP_SH_IR]  = '{TAP_SH_IR,  TAP_EX1_IR};
    succ[TAP_EX1_IR] = '{TAP_PAU_IR, TAP_UPD_IR};
    succ[TAP_PAU_IR] = '{TAP_PAU_IR, TAP_EX2_IR};
    succ[TAP_EX2_IR] = '{TAP_SH_IR,  TAP_UPD_IR};
    succ[TAP_UPD_IR] = '{TAP_RTI,    TAP_SEL_DR};
  endfunction

  function automatic void model_reset();
    m_state = TAP_TLR;
    m_ir    = OP_IDCODE;
    m_irq.delete();
    m_drq.delete();
    m_chain = 1'b0;
  endfunction

  function automatic ir_t eff_ir();
    return (m_state == TAP_TLR) ? OP_IDCODE : m_ir;
  endfunction

  function automatic void model_rise(input logic tms, input logic tdi);
    case (m_state)
      TAP_TLR:    m_ir = OP_IDCODE;
      TAP_CAP_IR: m_irq = '{1'b1, 1'b0, 1'b1, 1'b0};
      TAP_SH_IR: begin
        void'(m_irq.pop_front());
        m_irq.push_back(tdi);
      end
      TAP_UPD_IR: for (int i = 0; i < 4; i++) m_ir[i] = m_irq[i];
      TAP_CAP_DR: begin
        m_drq.delete();
        m_chain = (m_ir == OP_EXTEST) || (m_ir == OP_SAMPLE_PRELOAD);
        if (m_ir == OP_IDCODE) for (int i = 0; i < 32; i++) m_drq.push_back(IDC[i]);
        else if (!m_chain) m_drq.push_back(1'b0);
      end
      TAP_SH_DR: if (!m_chain) begin
        void'(m_drq.pop_front());
        m_drq.push_back(tdi);
      end
      default: ;
    endcase
    m_state = succ[m_state][tms];
  endfunction

  // ---------------- cycle driver ----------------
  logic s_tdo, s_oe, s_so;
  int   cnt_cap, cnt_upd, cnt_shift, cnt_oe;

  task automatic tick(input logic tms, input logic tdi);
    logic       so;
    ir_t        ir;
    logic [1:0] exp_tdo;
    so = 1'($urandom_range(0, 1));
    tms_i = tms;
    tdi_i = tdi;
    bs_if.bs_so = so;
    s_so = so;
    @(posedge clk_i);
    model_rise(tms, tdi);
    #1;
    ir = eff_ir();
    check("state", 64'(dut.u_fsm.state_q), 64'(m_state));
    check("ir", 64'(dut.ir_cur), 64'(ir));
    check("ctl", 64'({bs_if.shift_dr, bs_if.capture_dr, bs_if.update_dr,
                      bs_if.bs_enable, bs_if.bs_mode, bs_if.bs_si}),
                 64'({m_state == TAP_SH_DR, m_state == TAP_CAP_DR, m_state == TAP_UPD_DR,
                      (ir == OP_EXTEST) || (ir == OP_SAMPLE_PRELOAD), ir == OP_EXTEST, tdi}));
    if (bs_if.capture_dr) cnt_cap++;
    if (bs_if.update_dr)  cnt_upd++;
    if (bs_if.shift_dr)   cnt_shift++;
    @(negedge clk_i);
    #1;
    if (m_state == TAP_SH_IR)      exp_tdo = {1'b1, m_irq[0]};
    else if (m_state == TAP_SH_DR) exp_tdo = {1'b1, m_chain ? so : m_drq[0]};
    else                           exp_tdo = 2'b00;
    check("tdo_oe,tdo", 64'({tdo_oe_o, tdo_o}), 64'(exp_tdo));
    s_tdo = tdo_o;
    s_oe  = tdo_oe_o;
    if (tdo_oe_o) cnt_oe++;
  endtask

  // From RTI: load op into IR, return the 4 bits seen on TDO; ends in RTI.
  task automatic scan_ir(input ir_t op, output logic [3:0] tdo_bits);
    tdo_bits = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tdo_bits[0] = s_tdo;
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, op[i]);
      if (i < 3) tdo_bits[i+1] = s_tdo;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: n-bit DR scan; returns TDO bits and bs_so values seen.
  task automatic scan_dr(input logic [31:0] din, input int n,
                         output logic [31:0] dout, output logic [31:0] sos);
    dout = '0;
    sos  = '0;
    cnt_cap = 0; cnt_upd = 0; cnt_shift = 0; cnt_oe = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    dout[0] = s_tdo;
    sos[0]  = s_so;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      if (i < n - 1) begin
        dout[i+1] = s_tdo;
        sos[i+1]  = s_so;
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // Walk table: path from RTI (LSB = first TMS bit) reaching each state.
  typedef struct {
    tap_state_e target;
    logic [7:0] path;
    int         len;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  irb;
    logic [31:0] din, dout, sos;

    init_table();
    vecs[0]  = '{TAP_TLR,    8'b0000_0111, 3};
    vecs[1]  = '{TAP_RTI,    8'b0000_0000, 0};
    vecs[2]  = '{TAP_SEL_DR, 8'b0000_0001, 1};
    vecs[3]  = '{TAP_CAP_DR, 8'b0000_0001, 2};
    vecs[4]  = '{TAP_SH_DR,  8'b0000_0001, 3};
    vecs[5]  = '{TAP_EX1_DR, 8'b0000_0101, 3};
    vecs[6]  = '{TAP_PAU_DR, 8'b0000_0101, 4};
    vecs[7]  = '{TAP_EX2_DR, 8'b0001_0101, 5};
    vecs[8]  = '{TAP_UPD_DR, 8'b0000_1101, 4};
    vecs[9]  = '{TAP_SEL_IR, 8'b0000_0011, 2};
    vecs[10] = '{TAP_CAP_IR, 8'b0000_0011, 3};
    vecs[11] = '{TAP_SH_IR,  8'b0000_0011, 4};
    vecs[12] = '{TAP_EX1_IR, 8'b0000_1011, 4};
    vecs[13] = '{TAP_PAU_IR, 8'b0000_1011, 5};
    vecs[14] = '{TAP_EX2_IR, 8'b0010_1011, 6};
    vecs[15] = '{TAP_UPD_IR, 8'b0001_1011, 5};
    bs_if.bs_so = 1'b0;

    // Reset values
    #1 rst_ni = 1'b0;
    #2;
    check("rst_tdo", 64'({tdo_oe_o, tdo_o}), 64'(0));
    check("rst_ctl", 64'({bs_if.shift_dr, bs_if.capture_dr, bs_if.update_dr,
                          bs_if.bs_enable, bs_if.bs_mode}), 64'(0));
    check("rst_state", 64'(dut.u_fsm.state_q), 64'(TAP_TLR));
    check("rst_ir", 64'(dut.ir_cur), 64'(OP_IDCODE));
    check("rst_regs", 64'({dut.ir_sr_q, dut.id_sr_q, dut.byp_q}), 64'(0));
    model_reset();
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // IDCODE read straight after reset: TMS 0,1,0,0 then 32 shifts
    tick(1'b0, 1'b0);
    scan_dr(32'($urandom), 32, dout, sos);
    check("idcode_read", 64'(dout), 64'(IDC));
    check("idcode_oe_cycles", 64'(cnt_oe), 64'(32));

    // IR capture pattern and BYPASS delay
    scan_ir(OP_BYPASS, irb);
    check("ir_capture_out", 64'(irb), 64'(4'b0101));
    check("ir_bypass", 64'(dut.ir_cur), 64'(OP_BYPASS));
    scan_dr(32'b1101, 4, dout, sos);
    check("bypass_1011", 64'(dout[3:0]), 64'(4'b1010));

    // EXTEST: chain selected, strobes counted over one 8-bit scan
    scan_ir(OP_EXTEST, irb);
    check("extest_bs", 64'({bs_if.bs_enable, bs_if.bs_mode}), 64'(2'b11));
    scan_dr(32'($urandom), 8, dout, sos);
    check("extest_capture_cnt", 64'(cnt_cap), 64'(1));
    check("extest_update_cnt", 64'(cnt_upd), 64'(1));
    check("extest_shift_cnt", 64'(cnt_shift), 64'(8));
    check("extest_tdo_mirror", 64'(dout[7:0]), 64'(sos[7:0]));

    scan_ir(OP_SAMPLE_PRELOAD, irb);
    check("sample_bs", 64'({bs_if.bs_enable, bs_if.bs_mode}), 64'(2'b10));

    // Unlisted opcode acts as BYPASS
    scan_ir(4'b0110, irb);
    check("op0110_bs_enable", 64'(bs_if.bs_enable), 64'(0));
    din = 32'($urandom);
    scan_dr(din, 6, dout, sos);
    check("op0110_bypass", 64'(dout[5:0]), 64'({din[4:0], 1'b0}));

    // Every state returns to TLR with IDCODE after five TMS=1 rises
    for (int v = 0; v < 16; v++) begin
      repeat (5) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      scan_ir(OP_BYPASS, irb);
      for (int i = 0; i < vecs[v].len; i++) tick(vecs[v].path[i], 1'($urandom_range(0, 1)));
      check($sformatf("reach_%0d", v), 64'(dut.u_fsm.state_q), 64'(vecs[v].target));
      repeat (5) tick(1'b1, 1'b0);
      check($sformatf("tlr_from_%0d", v), 64'(dut.u_fsm.state_q), 64'(TAP_TLR));
      check($sformatf("ir_idcode_from_%0d", v), 64'(dut.ir_cur), 64'(OP_IDCODE));
    end

    // Reset pulsed while bit 10 of IDCODE is on TDO
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    check("id_bit10", 64'({s_oe, s_tdo}), 64'({1'b1, IDC[10]}));
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_tdo", 64'({tdo_oe_o, tdo_o}), 64'(0));
    check("midrst_state", 64'(dut.u_fsm.state_q), 64'(TAP_TLR));
    check("midrst_ir", 64'(dut.ir_cur), 64'(OP_IDCODE));
    model_reset();
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    tick(1'b0, 1'b0);
    scan_dr(32'($urandom), 32, dout, sos);
    check("idcode_after_rst", 64'(dout), 64'(IDC));

    // Randomized TMS/TDI against the model
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_jtag_tap_ctrl

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IDCODE_VALUE, default 32'h1234_5677, device ID; bit 0 must be 1.
REQ-002 SHALL have port clk_i  in  1  TCK; reset rst_ni, asynchronous, active-low (TRST_N).
REQ-003 SHALL have port tms_i  in  1  test mode select, sampled on clk_i rise.
REQ-004 SHALL have port tdi_i  in  1  serial test data in.
REQ-005 SHALL have port tdo_o  out  1  serial test data out, changes on clk_i fall.
REQ-006 SHALL have port tdo_oe_o  out  1  TDO drive enable.
REQ-007 SHALL have ports shift_dr_o, capture_dr_o, update_dr_o  out  1 each  boundary-scan chain control.
REQ-008 SHALL have port bs_enable_o  out  1  chain enable; bs_mode_o  out  1  cell output select.
REQ-009 SHALL have port bs_si_o  out  1  chain serial in (= tdi_i); bs_so_i  in  1  chain serial out.

Function
REQ-010 SHALL implement the 16-state IEEE 1149.1 TAP FSM (TLR, RTI, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the IR equivalents), advancing on each clk_i rise per tms_i.
REQ-011 SHALL reach TLR after 5 consecutive tms_i=1 rises from any state.
REQ-012 SHALL use a 4-bit IR; opcodes EXTEST=0000, SAMPLE_PRELOAD=0001, IDCODE=0010, BYPASS=1111; any other code SHALL act as BYPASS.
REQ-013 SHALL load 4'b0101 into the IR shift stage in CAPTURE_IR; shift right (tdi_i into MSB) in SHIFT_IR; copy to IR in UPDATE_IR; IR SHALL be IDCODE while in TLR.
REQ-014 SHALL decode shift_dr_o/capture_dr_o/update_dr_o combinationally from current state (high for exactly the cycles spent in SHIFT_DR/CAPTURE_DR/UPDATE_DR), regardless of IR.
REQ-015 SHALL drive bs_enable_o=1 iff IR is EXTEST or SAMPLE_PRELOAD; bs_mode_o=1 iff IR is EXTEST.
REQ-016 SHALL clear a 1-bit bypass register in CAPTURE_DR and load tdi_i into it in SHIFT_DR.
REQ-017 SHALL load IDCODE_VALUE into a 32-bit ID shift register in CAPTURE_DR when IR=IDCODE, and shift right (tdi_i into bit 31) in SHIFT_DR.
REQ-018 SHALL select TDO source: SHIFT_IR -> IR shift bit 0; SHIFT_DR -> ID bit 0 (IDCODE), bs_so_i (EXTEST/SAMPLE_PRELOAD), bypass bit (otherwise).
REQ-019 SHALL register tdo_o and tdo_oe_o on clk_i fall; tdo_oe_o=1 only in SHIFT_DR/SHIFT_IR; tdo_o=0 when not shifting.
REQ-020 SHALL hold all shift registers in PAUSE/EXIT states (no shift, no capture).

Reset
REQ-021 SHALL on rst_ni low, asynchronously: state=TLR, IR=IDCODE, IR shift=0, ID shift=0, bypass=0, tdo_o=0, tdo_oe_o=0.
REQ-022 SHALL, reset asserted mid-shift, abort immediately; the next shift after release SHALL start from fresh capture values.
REQ-023 SHALL have control outputs at reset: shift/capture/update_dr_o=0, bs_enable_o=0, bs_mode_o=0.

Structure
REQ-024 SHALL place the TAP state enum, IR width (4) and opcode constants in shared package jtag_tap_pkg.
REQ-025 SHALL implement the 16-state FSM as sub-module jtag_tap_fsm (inputs tms_i, clk_i, rst_ni; output state).
REQ-026 SHALL contain no other clock than clk_i (rise and fall edges only).

Verification
REQ-027 SHALL verify: from each of the 16 states, tms_i=1 for 5 rises -> state TLR, IR=0010.
REQ-028 SHALL verify: after reset, TMS 0,1,0,0 then 32 SHIFT_DR cycles -> tdo_o yields 0x12345677 LSB first; tdo_oe_o high only those 32 cycles.
REQ-029 SHALL verify: SHIFT_IR 4 cycles with tdi_i=1 -> TDO yields 1,0,1,0; after UPDATE_IR IR=1111; DR shift of pattern 1011 -> TDO emits 0,1,0,1... delayed one bit (leading 0).
REQ-030 SHALL verify: load EXTEST -> bs_mode_o=1, bs_enable_o=1; one DR scan -> capture_dr_o and update_dr_o each high exactly 1 cycle, shift_dr_o high N cycles, TDO mirrors bs_so_i.
REQ-031 SHALL verify: IR opcode 0110 -> bypass behaviour, bs_enable_o=0.
REQ-032 SHALL verify: rst_ni pulsed low during SHIFT_DR bit 10 of IDCODE -> tdo_oe_o=0 immediately, state TLR, IR=0010.
